// File: rtl/axis_skid_buffer_if.sv
// AXI-Stream channel bundle (valid/ready/data) used on both sides of the skid buffer.
interface axis_skid_buffer_if #(
    parameter int BUS_W = 8
) ();
    logic             valid;
    logic             ready;
    logic [BUS_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: every output is a flop, one beat per clock, order preserved.
// Define SKID_BUFFER_ASSERTIONS_EN to compile in the protocol checker.
module axis_skid_buffer #(
    parameter int BUS_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    axis_skid_buffer_if.slave        s,
    axis_skid_buffer_if.master       m
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Power-on values match the reset values so the slice works without a reset pulse.
    state_e           state_r     = ST_EMPTY;
    logic             m_valid_r   = 1'b0;
    logic             s_ready_r   = 1'b1;
    logic [BUS_W-1:0] m_data_r    = {BUS_W{1'b0}};
    logic [BUS_W-1:0] skid_data_r = {BUS_W{1'b0}};

    state_e           state_s;
    logic             m_valid_s;
    logic             s_ready_s;
    logic [BUS_W-1:0] m_data_s;
    logic [BUS_W-1:0] skid_data_s;
    logic             in_hs_s;
    logic             out_hs_s;

    // Handshake decode from registered ready/valid only.
    always_comb begin
        in_hs_s  = s.valid & s_ready_r;
        out_hs_s = m_valid_r & m.ready;
    end

    // Next-state and next-register values.
    always_comb begin
        state_s     = state_r;
        m_data_s    = m_data_r;
        skid_data_s = skid_data_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_hs_s) begin
                    m_data_s = s.data;
                    state_s  = ST_BUSY;
                end else begin
                    state_s  = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (in_hs_s && out_hs_s) begin
                    m_data_s = s.data;
                    state_s  = ST_BUSY;
                end else if (in_hs_s) begin
                    skid_data_s = s.data;
                    state_s     = ST_FULL;
                end else if (out_hs_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (out_hs_s) begin
                    m_data_s = skid_data_r;
                    state_s  = ST_BUSY;
                end else begin
                    state_s  = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
        // Flags are decoded from the next state so they land in flops alongside it.
        m_valid_s = (state_s != ST_EMPTY);
        s_ready_s = (state_s != ST_FULL);
    end

    // State and handshake flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_EMPTY;
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            m_valid_r <= m_valid_s;
            s_ready_r <= s_ready_s;
        end
    end

    // Output and skid data registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_data_r    <= {BUS_W{1'b0}};
            skid_data_r <= {BUS_W{1'b0}};
        end else begin
            m_data_r    <= m_data_s;
            skid_data_r <= skid_data_s;
        end
    end

    assign m.valid = m_valid_r;
    assign m.data  = m_data_r;
    assign s.ready = s_ready_r;

`ifdef SKID_BUFFER_ASSERTIONS_EN
    logic skid_valid_s;
    assign skid_valid_s = (state_r == ST_FULL);

    axis_skid_buffer_chk #(.BUS_W(BUS_W)) u_chk (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s.valid),
        .s_ready    (s_ready_r),
        .m_valid    (m_valid_r),
        .m_ready    (m.ready),
        .m_data     (m_data_r),
        .skid_valid (skid_valid_s)
    );
`endif
endmodule

`ifdef SKID_BUFFER_ASSERTIONS_EN
// Protocol checker bound inside the slice when assertions are enabled.
module axis_skid_buffer_chk #(
    parameter int BUS_W = 8
) (
    input logic             clk,
    input logic             rstn,
    input logic             s_valid,
    input logic             s_ready,
    input logic             m_valid,
    input logic             m_ready,
    input logic [BUS_W-1:0] m_data,
    input logic             skid_valid
);
    a_hold: assert property (@(posedge clk) disable iff (!rstn)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)))
        else $error("skid buffer: output changed under backpressure");

    a_ready_when_empty: assert property (@(posedge clk) disable iff (!rstn)
        (!skid_valid && !m_valid) |-> s_ready)
        else $error("skid buffer: s_ready low while empty");

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        skid_valid |-> !(s_valid && s_ready))
        else $error("skid buffer: input accepted while full");

    a_no_x: assert property (@(posedge clk) disable iff (!rstn)
        !$isunknown({m_valid, s_ready}))
        else $error("skid buffer: X on m_valid or s_ready");
endmodule
`endif

// File: tb/tb_axis_skid_buffer.sv
// Directed and random test of axis_skid_buffer with a queue scoreboard on the stream.
module tb_axis_skid_buffer;
    localparam int NPKT   = 300;
    localparam int NBEATS = NPKT * 10;
    localparam int BUDGET = 90000;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   rx_count = 0;
    logic [7:0] exp_q[$];

    axis_skid_buffer_if #(.BUS_W(8)) up ();
    axis_skid_buffer_if #(.BUS_W(8)) dn ();

    axis_skid_buffer #(.BUS_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .s    (up),
        .m    (dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: push accepted inputs, pop and compare on every output beat.
    always @(negedge clk) begin
        if (rstn) begin
            if (up.valid && up.ready) exp_q.push_back(up.data);
            if (dn.valid && dn.ready) begin
                check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("sb_data", {24'd0, dn.data}, {24'd0, exp_q.pop_front()});
                    rx_count++;
                end
            end
        end
    end

    // Buffered beats are discarded by reset.
    always @(negedge rstn) exp_q.delete();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  sent;
        int  cyc;
        int  rx0;
        logic hs;

        rstn     = 1'b0;
        up.valid = 1'b0;
        up.data  = 8'h00;
        dn.ready = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        check("rst_m_valid", {31'd0, dn.valid}, 32'd0);
        check("rst_s_ready", {31'd0, up.ready}, 32'd1);
        check("rst_m_data",  {24'd0, dn.data},  32'd0);

        // Pass-through at full rate.
        dn.ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            up.valid = 1'b1;
            up.data  = 8'(i);
            step();
            check("pt_m_valid", {31'd0, dn.valid}, 32'd1);
            check("pt_m_data",  {24'd0, dn.data},  32'(i));
            check("pt_s_ready", {31'd0, up.ready}, 32'd1);
        end
        up.valid = 1'b0;
        step();
        step();
        check("pt_drained", {31'd0, dn.valid}, 32'd0);

        // Skid fill.
        dn.ready = 1'b0;
        up.valid = 1'b1;
        up.data  = 8'h11;
        step();
        up.data  = 8'h22;
        step();
        up.valid = 1'b0;
        check("skid_s_ready", {31'd0, up.ready}, 32'd0);
        check("skid_m_data",  {24'd0, dn.data},  32'h11);
        step();
        check("skid_hold",    {24'd0, dn.data},  32'h11);
        dn.ready = 1'b1;
        step();
        check("skid_second",  {24'd0, dn.data},  32'h22);
        check("skid_ready_up", {31'd0, up.ready}, 32'd1);
        step();
        check("skid_empty",   {31'd0, dn.valid}, 32'd0);

        // Backpressure hold with toggling input data.
        dn.ready = 1'b0;
        up.valid = 1'b1;
        up.data  = 8'h5A;
        step();
        for (int i = 0; i < 20; i++) begin
            up.data = (i % 2 == 0) ? 8'hC3 : 8'h3C;
            step();
            check("bp_m_valid", {31'd0, dn.valid}, 32'd1);
            check("bp_m_data",  {24'd0, dn.data},  32'h5A);
        end
        up.valid = 1'b0;
        dn.ready = 1'b1;
        step();
        check("bp_first_queued", {24'd0, dn.data}, 32'hC3);
        step();
        check("bp_drained", {31'd0, dn.valid}, 32'd0);

        // Asynchronous reset while FULL.
        dn.ready = 1'b0;
        up.valid = 1'b1;
        up.data  = 8'h44;
        step();
        up.data  = 8'h55;
        step();
        up.valid = 1'b0;
        check("full_before_rst", {31'd0, up.ready}, 32'd0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_m_valid", {31'd0, dn.valid}, 32'd0);
        check("arst_s_ready", {31'd0, up.ready}, 32'd1);
        check("arst_m_data",  {24'd0, dn.data},  32'd0);
        step();
        rstn = 1'b1;
        dn.ready = 1'b1;
        step();
        check("post_rst_idle", {31'd0, dn.valid}, 32'd0);
        up.valid = 1'b1;
        up.data  = 8'h33;
        step();
        up.valid = 1'b0;
        check("post_rst_beat", {24'd0, dn.data}, 32'h33);
        check("post_rst_valid", {31'd0, dn.valid}, 32'd1);
        step();
        check("post_rst_alone", {31'd0, dn.valid}, 32'd0);

        // Empty idle.
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_m_valid", {31'd0, dn.valid}, 32'd0);
            check("idle_s_ready", {31'd0, up.ready}, 32'd1);
        end

        // Random handshakes at 10% duty; source holds a beat until accepted.
        rx0  = rx_count;
        sent = 0;
        cyc  = 0;
        dn.ready = 1'b0;
        while ((sent < NBEATS) && (cyc < BUDGET)) begin
            @(negedge clk);
            hs = up.valid && up.ready;
            step();
            cyc++;
            if (hs) sent++;
            if (!(up.valid && !hs)) begin
                if ((sent < NBEATS) && ($urandom_range(9, 0) == 0)) begin
                    up.valid = 1'b1;
                    up.data  = 8'($urandom_range(255, 0));
                end else begin
                    up.valid = 1'b0;
                end
            end
            dn.ready = ($urandom_range(9, 0) == 0);
        end
        up.valid = 1'b0;
        dn.ready = 1'b1;
        cyc = 0;
        while ((rx_count != rx0 + sent) && (cyc < 100)) begin
            step();
            cyc++;
        end
        check("rand_sent", 32'(sent), 32'(NBEATS));
        check("rand_received", 32'(rx_count - rx0), 32'(NBEATS));
        check("sb_left_over", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
